// File: rtl/tdm_demux12.sv
// tdm_demux12 -- receive-side demultiplexer for an alternating A,B word stream.
//
// Locks onto the A,B alternation (A words carry din_sof), steers each word into
// a registered per-channel output with one-cycle valid strobes, flags and counts
// alternation violations, and re-acquires lock on the next A word.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   din               multiplexed input word (WIDTH bits)
//   din_valid         din carries a word this cycle
//   din_sof           din is a channel-A word; ignored when din_valid=0
//   a_out, b_out      last captured channel-A / channel-B word
//   a_valid, b_valid  one-cycle pulse: corresponding output updated
//   pair_valid        one-cycle pulse: a_out/b_out form a complete frame
//   locked            state is EXP_B or EXP_A
//   sync_err          one-cycle pulse on an alternation violation
//   err_cnt           saturating count of sync_err pulses (ERRW bits)
module tdm_demux12 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             a_valid,
    output logic             b_valid,
    output logic             pair_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [ERRW-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_B = 2'd1,
        EXP_A = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_out_q, a_out_d;
    logic [WIDTH-1:0]  b_out_q, b_out_d;
    logic              a_valid_q, a_valid_d;
    logic              b_valid_q, b_valid_d;
    logic              pair_valid_q, pair_valid_d;
    logic              sync_err_q, sync_err_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    always_comb begin
        state_d      = state_q;
        a_out_d      = a_out_q;
        b_out_d      = b_out_q;
        a_valid_d    = 1'b0;
        b_valid_d    = 1'b0;
        pair_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Non-A words while hunting are dropped silently.
                    if (din_sof) begin
                        a_out_d   = din;
                        a_valid_d = 1'b1;
                        state_d   = EXP_B;
                    end
                end
                EXP_B: begin
                    // A repeated A word is still a good A word: keep it and
                    // keep waiting for its B partner.
                    a_out_d = din_sof ? din : a_out_q;
                    if (din_sof) begin
                        a_valid_d  = 1'b1;
                        sync_err_d = 1'b1;
                    end else begin
                        b_out_d      = din;
                        b_valid_d    = 1'b1;
                        pair_valid_d = 1'b1;
                        state_d      = EXP_A;
                    end
                end
                EXP_A: begin
                    if (din_sof) begin
                        a_out_d   = din;
                        a_valid_d = 1'b1;
                        state_d   = EXP_B;
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            a_out_q      <= '0;
            b_out_q      <= '0;
            a_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            pair_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            a_valid_q    <= a_valid_d;
            b_valid_q    <= b_valid_d;
            pair_valid_q <= pair_valid_d;
            sync_err_q   <= sync_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
    assign pair_valid = pair_valid_q;
    assign sync_err   = sync_err_q;
    assign err_cnt    = err_cnt_q;
    assign locked     = (state_q != HUNT);

endmodule
